// File: rtl/store_buffer_unit_if.sv
// Store port bundle between the execute stage, store_buffer_unit and the memory write port.
// The slave modport is the buffer's view; master is the execute/memory side.
interface store_buffer_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int BUS_W  = 128,
  parameter int DEPTH  = 4
);
  localparam int LANES = BUS_W / DATA_W;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              StartIn;
  logic [DATA_W-1:0] ResultIn;
  logic [ADDR_W-1:0] StoreAddressIn;
  logic              WriteReady;
  logic [BUS_W-1:0]  WriteBus;
  logic [ADDR_W-1:0] WriteAddress;
  logic              WriteEnable;
  logic [LANES-1:0]  WriteMask;
  logic              StallOut;
  logic              Overflow;
  logic [CW-1:0]     Count;
  logic              done;

  modport slave (
    input  StartIn, ResultIn, StoreAddressIn, WriteReady,
    output WriteBus, WriteAddress, WriteEnable, WriteMask,
           StallOut, Overflow, Count, done
  );

  modport master (
    output StartIn, ResultIn, StoreAddressIn, WriteReady,
    input  WriteBus, WriteAddress, WriteEnable, WriteMask,
           StallOut, Overflow, Count, done
  );
endinterface

// File: rtl/store_buffer_unit.sv
// Write-back store buffer: queues (result, address) requests and presents them in order
// on a registered memory write port, zero-extended or lane-aligned onto the wide bus.
module store_buffer_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int BUS_W     = 128,
  parameter int DEPTH     = 4,
  parameter int LANE_MODE = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  store_buffer_unit_if.slave  bus
);
  localparam int LANES = BUS_W / DATA_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int LWS   = (LW > 0) ? LW : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int FD    = (DEPTH > 1) ? DEPTH - 1 : 1;
  localparam int PW    = (FD > 1) ? $clog2(FD) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FD - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     fifoCnt_q, fifoCnt_d;
  logic [PW-1:0]     rdPtr_q, wrPtr_q;
  logic [DATA_W-1:0] fifoData_q [FD];
  logic [ADDR_W-1:0] fifoAddr_q [FD];
  logic [BUS_W-1:0]  wbus_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [LANES-1:0]  wmask_q;
  logic              stall_q, ovf_q, done_q;

  logic              accept, complete, fifoEmpty, loadFifo, loadBypass, push;
  logic [DATA_W-1:0] srcData;
  logic [ADDR_W-1:0] srcAddr;
  logic [BUS_W-1:0]  srcBus;
  logic [LANES-1:0]  srcMask;
  int                srcLane;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Lane selection uses only the low address bits; zero-extend mode always targets lane 0.
  function automatic int laneOf(input logic [ADDR_W-1:0] a);
    if (LANE_MODE != 0 && LANES > 1) return int'(a[LWS-1:0]);
    return 0;
  endfunction

  assign accept     = bus.StartIn && (cnt_q < DEPTH_C);
  assign complete   = (state_q == SEND) && bus.WriteReady;
  assign fifoEmpty  = (fifoCnt_q == '0);
  assign loadFifo   = complete && !fifoEmpty;
  assign loadBypass = accept && ((state_q == IDLE) || (complete && fifoEmpty));
  assign push       = accept && !loadBypass;
  assign cnt_d      = cnt_q + CW'(accept) - CW'(complete);
  assign fifoCnt_d  = fifoCnt_q + CW'(push) - CW'(loadFifo);

  always_comb begin
    srcData = bus.ResultIn;
    srcAddr = bus.StoreAddressIn;
    srcBus  = '0;
    srcMask = '0;
    if (loadFifo) begin
      srcData = fifoData_q[rdPtr_q];
      srcAddr = fifoAddr_q[rdPtr_q];
    end
    srcLane = laneOf(srcAddr);
    for (int l = 0; l < LANES; l++) begin
      if (l == srcLane) begin
        srcBus[l*DATA_W +: DATA_W] = srcData;
        srcMask[l] = 1'b1;
      end
    end
  end

  // FIFO head always wins over a bypass so writes leave in acceptance order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fifoCnt_q <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      wbus_q    <= '0;
      waddr_q   <= '0;
      wmask_q   <= '0;
      stall_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b1;
      for (int i = 0; i < FD; i++) begin
        fifoData_q[i] <= '0;
        fifoAddr_q[i] <= '0;
      end
    end else begin
      if (loadFifo || loadBypass) begin
        state_q <= SEND;
        wbus_q  <= srcBus;
        waddr_q <= srcAddr;
        wmask_q <= srcMask;
      end else if (complete) begin
        state_q <= IDLE;
        wbus_q  <= '0;
        waddr_q <= '0;
        wmask_q <= '0;
      end
      if (push) begin
        fifoData_q[wrPtr_q] <= bus.ResultIn;
        fifoAddr_q[wrPtr_q] <= bus.StoreAddressIn;
        wrPtr_q             <= nextPtr(wrPtr_q);
      end
      if (loadFifo) begin
        rdPtr_q <= nextPtr(rdPtr_q);
      end
      fifoCnt_q <= fifoCnt_d;
      cnt_q     <= cnt_d;
      stall_q   <= (cnt_d == DEPTH_C);
      done_q    <= (cnt_d == '0);
      if (bus.StartIn && (cnt_q == DEPTH_C)) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.WriteEnable  = (state_q == SEND);
  assign bus.WriteBus     = wbus_q;
  assign bus.WriteAddress = waddr_q;
  assign bus.WriteMask    = wmask_q;
  assign bus.StallOut     = stall_q;
  assign bus.Overflow     = ovf_q;
  assign bus.Count        = cnt_q;
  assign bus.done         = done_q;
endmodule
